// File: rtl/n64_vinfo_ext.sv
// n64_vinfo_ext: front-end video-info extractor for the N64 digital video bus.
// Tracks the 4-phase nDSYNC word cycle, keeps the previous sync word for edge
// detection, counts lines per field and classifies each field as NTSC/PAL and
// progressive/interlaced from sync timing alone.
// Optional feature macro: VINFO_FILTER_EN. When it is defined, vmode and
// n64_480i only change once the raw classification agrees over two
// consecutive valid fields. When it is undefined, they follow the raw
// classification directly.
// Reset: nRST, synchronous, active-low, sampled on VCLK.
module n64_vinfo_ext #(
  parameter int COLOR_W    = 7,
  parameter int LINE_CNT_W = 10,
  parameter logic [LINE_CNT_W-1:0] PAL_LINE_TH = 10'd288
) (
  input  logic               VCLK,
  input  logic               nRST,
  input  logic               nDSYNC,
  input  logic [COLOR_W-1:0] D_i,
  output logic [1:0]         data_cnt,
  output logic [3:0]         sync_pre,
  output logic               vsync_neg,
  output logic               vmode,
  output logic               n64_480i,
  output logic               field_id
);

  // Bit positions of the control signals inside a sync word.
  localparam int VSYNC_BIT = 3;
  localparam int HSYNC_BIT = 1;

  logic                  sync_word;
  logic                  vs_fall;
  logic                  hs_fall;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic                  line_cnt_max;
  logic                  frame_valid;
  logic                  class_en;
  logic                  vmode_raw;
  logic                  i480_raw;
  logic                  unused_hi;

  // The colour bits above the sync nibble carry no timing information.
  assign unused_hi = ^D_i[COLOR_W-1:4];

  // Sync edge detection against the previous sync word; only sync cycles count.
  always_comb begin
    sync_word    = 1'b0;
    vs_fall      = 1'b0;
    hs_fall      = 1'b0;
    sync_word    = ~nDSYNC;
    vs_fall      = sync_word & sync_pre[VSYNC_BIT] & ~D_i[VSYNC_BIT];
    hs_fall      = sync_word & sync_pre[HSYNC_BIT] & ~D_i[HSYNC_BIT];
  end

  // Word phase counter: a sync word forces the next phase to R, otherwise it wraps freely.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      data_cnt <= 2'd0;
    end else if (sync_word) begin
      data_cnt <= 2'd1;
    end else begin
      data_cnt <= data_cnt + 2'd1;
    end
  end

  // Previous sync word register, refreshed only on sync cycles.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      sync_pre <= 4'hF;
    end else if (sync_word) begin
      sync_pre <= D_i[3:0];
    end
  end

  // One-cycle strobe following the sync word that carries the nVSYNC falling edge.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      vsync_neg <= 1'b0;
    end else begin
      vsync_neg <= vs_fall;
    end
  end

  assign line_cnt_max = &line_cnt;

  // Line counter per field: vsync clear wins over a coincident hsync, saturates at all-ones.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      line_cnt <= '0;
    end else if (vs_fall) begin
      line_cnt <= '0;
    end else if (hs_fall && !line_cnt_max) begin
      line_cnt <= line_cnt + 1'b1;
    end
  end

  // Field bookkeeping: the first vsync after reset only arms classification.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      frame_valid <= 1'b0;
      field_id    <= 1'b0;
    end else if (vs_fall) begin
      frame_valid <= 1'b1;
      field_id    <= D_i[HSYNC_BIT];
    end
  end

  // Raw classification of the field that just ended.
  always_comb begin
    class_en  = 1'b0;
    vmode_raw = 1'b0;
    i480_raw  = 1'b0;
    class_en  = vs_fall & frame_valid;
    vmode_raw = (line_cnt >= PAL_LINE_TH);
    i480_raw  = (D_i[HSYNC_BIT] != field_id);
  end

`ifdef VINFO_FILTER_EN
  logic vmode_pend;
  logic i480_pend;

  // Filtered outputs: each output moves only when two consecutive raw values agree.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      vmode_pend <= 1'b0;
      i480_pend  <= 1'b0;
      vmode      <= 1'b0;
      n64_480i   <= 1'b0;
    end else if (class_en) begin
      vmode_pend <= vmode_raw;
      i480_pend  <= i480_raw;
      if (vmode_raw == vmode_pend) begin
        vmode <= vmode_raw;
      end
      if (i480_raw == i480_pend) begin
        n64_480i <= i480_raw;
      end
    end
  end
`else
  // Direct outputs: take the raw classification at every valid vsync.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      vmode    <= 1'b0;
      n64_480i <= 1'b0;
    end else if (class_en) begin
      vmode    <= vmode_raw;
      n64_480i <= i480_raw;
    end
  end
`endif

endmodule

// File: tb/tb_n64_vinfo_ext.sv
// Testbench for n64_vinfo_ext. Builds sync words, lines and fields, and checks
// every cycle against a field-level behavioural model plus literal checkpoints.
module tb_n64_vinfo_ext;

  logic       VCLK;
  logic       nRST;
  logic       nDSYNC;
  logic [6:0] D_i;
  logic [1:0] data_cnt;
  logic [3:0] sync_pre;
  logic       vsync_neg;
  logic       vmode;
  logic       n64_480i;
  logic       field_id;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  n64_vinfo_ext dut (
    .VCLK      (VCLK),
    .nRST      (nRST),
    .nDSYNC    (nDSYNC),
    .D_i       (D_i),
    .data_cnt  (data_cnt),
    .sync_pre  (sync_pre),
    .vsync_neg (vsync_neg),
    .vmode     (vmode),
    .n64_480i  (n64_480i),
    .field_id  (field_id)
  );

  // Clock and reset block
  initial begin
    VCLK = 1'b0;
    forever #5 VCLK = ~VCLK;
  end

  // ---------------- behavioural model ----------------
  // Values the outputs must hold after the most recent clock edge.
  int       m_dc;
  logic [3:0] m_prev;
  int       m_lines;
  bit       m_valid;
  bit       m_fid;
  bit       m_vmode;
  bit       m_i480;
  bit       m_vneg;
`ifdef VINFO_FILTER_EN
  bit       vm_hist[$];
  bit       i_hist[$];
`endif

  task automatic model_reset();
    m_dc = 0; m_prev = 4'hF; m_lines = 0; m_valid = 0; m_fid = 0;
    m_vmode = 0; m_i480 = 0; m_vneg = 0;
`ifdef VINFO_FILTER_EN
    vm_hist.delete();
    i_hist.delete();
`endif
  endtask

  task automatic model_classify(input bit rv, input bit ri);
`ifdef VINFO_FILTER_EN
    bit pv, pi;
    pv = (vm_hist.size() > 0) ? vm_hist[$] : 1'b0;
    pi = (i_hist.size() > 0) ? i_hist[$] : 1'b0;
    if (pv == rv) m_vmode = rv;
    if (pi == ri) m_i480 = ri;
    vm_hist.push_back(rv);
    i_hist.push_back(ri);
`else
    m_vmode = rv;
    m_i480  = ri;
`endif
  endtask

  task automatic model_step(input bit rst_n, input bit nd, input logic [6:0] d);
    bit vf, hf;
    vf = 0;
    hf = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_dc = nd ? (m_dc + 1) % 4 : 1;
    if (!nd) begin
      vf = m_prev[3] && !d[3];
      hf = m_prev[1] && !d[1];
      m_prev = d[3:0];
    end
    m_vneg = vf;
    if (vf) begin
      if (m_valid) model_classify(m_lines >= 288, d[1] != m_fid);
      m_valid = 1;
      m_fid   = d[1];
      m_lines = 0;
    end else if (hf) begin
      m_lines = (m_lines < 1023) ? m_lines + 1 : 1023;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge VCLK);
      if (check_en) begin
        check("data_cnt", data_cnt, m_dc);
        check("sync_pre", sync_pre, m_prev);
        check("vsync_neg", vsync_neg, m_vneg);
        check("vmode", vmode, m_vmode);
        check("n64_480i", n64_480i, m_i480);
        check("field_id", field_id, m_fid);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit nd, input logic [6:0] d);
    nDSYNC = nd;
    D_i    = d;
    @(posedge VCLK);
    model_step(1'b1, nd, d);
    #1;
  endtask

  task automatic do_reset(input int n);
    nRST   = 1'b0;
    nDSYNC = 1'b1;
    repeat (n) begin
      D_i = 7'($urandom);
      @(posedge VCLK);
      model_step(1'b0, 1'b1, D_i);
      #1;
    end
    nRST = 1'b1;
  endtask

  function automatic logic [6:0] sync_val(input bit vs, input bit hs);
    return {3'($urandom), vs, 1'($urandom), hs, 1'($urandom)};
  endfunction

  task automatic word(input bit vs, input bit hs);
    cycle(1'b0, sync_val(vs, hs));
    repeat (3) cycle(1'b1, 7'($urandom));
  endtask

  task automatic vs_edge(input bit hs);
    cycle(1'b0, sync_val(1'b0, hs));
    check("vsync_neg_edge", vsync_neg, 1);
    repeat (3) cycle(1'b1, 7'($urandom));
  endtask

  // Raises nVSYNC again, then emits `lines` hsync pulses ending with nHSYNC high.
  task automatic body(input int lines);
    word(1'b1, 1'b1);
    for (int i = 0; i < lines; i++) begin
      word(1'b1, 1'b0);
      word(1'b1, 1'b1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0; nDSYNC = 1'b1; D_i = '0;
    model_reset();
    do_reset(2);
    check_en = 1;

    // Reset state
    check("rst_data_cnt", data_cnt, 0);
    check("rst_sync_pre", sync_pre, 4'hF);
    check("rst_vsync_neg", vsync_neg, 0);
    check("rst_vmode", vmode, 0);
    check("rst_n64_480i", n64_480i, 0);
    check("rst_field_id", field_id, 0);

    // Phase counting, with one dropped nDSYNC pulse in word 5
    for (int w = 0; w < 10; w++) begin
      for (int p = 0; p < 4; p++) begin
        if (p == 0 && w != 5) cycle(1'b0, sync_val(1'b1, 1'b1));
        else                  cycle(1'b1, 7'($urandom));
        check("data_cnt_phase", data_cnt, (p + 1) % 4);
      end
    end

    // NTSC progressive: first vsync only arms, then 3 classified fields
    vs_edge(1'b1);
    for (int f = 0; f < 3; f++) begin
      body(262);
      vs_edge(1'b1);
    end
    check("ntsc_vmode", vmode, 0);
    check("ntsc_480i", n64_480i, 0);

    // Saturated line counter classifies as PAL, then a 312-line field
    body(1030);
    vs_edge(1'b1);
`ifdef VINFO_FILTER_EN
    check("sat_vmode_first", vmode, 0);
`else
    check("sat_vmode_first", vmode, 1);
`endif
    body(312);
    vs_edge(1'b1);
    check("pal_vmode", vmode, 1);

    // Threshold boundary: 287 lines is NTSC, 288 lines is PAL
    repeat (2) begin body(287); vs_edge(1'b1); end
    check("vmode_287", vmode, 0);
    repeat (2) begin body(288); vs_edge(1'b1); end
    check("vmode_288", vmode, 1);

    // Reset mid-field
    body(150);
    do_reset(1);
    check("midrst_vmode", vmode, 0);
    check("midrst_480i", n64_480i, 0);
    check("midrst_sync_pre", sync_pre, 4'hF);
    check("midrst_data_cnt", data_cnt, 0);
    check("midrst_field_id", field_id, 0);
    vs_edge(1'b1);
    check("midrst_arm_vmode", vmode, 0);
    check("midrst_arm_fid", field_id, 1);
    body(312);
    vs_edge(1'b1);
`ifdef VINFO_FILTER_EN
    check("midrst_first_vmode", vmode, 0);
`else
    check("midrst_first_vmode", vmode, 1);
`endif
    body(312);
    vs_edge(1'b1);
    check("midrst_second_vmode", vmode, 1);

    // Interlace: nHSYNC level at vsync alternates; low edges are simultaneous falls
    body(262); vs_edge(1'b0); check("il_fid0", field_id, 0);
    body(263); vs_edge(1'b1); check("il_fid1", field_id, 1);
    body(262); vs_edge(1'b0); check("il_fid2", field_id, 0);
    check("il_480i", n64_480i, 1);
    check("il_vmode", vmode, 0);

    // Back to a constant phase
    body(263); vs_edge(1'b1);
    body(262); vs_edge(1'b1);
`ifdef VINFO_FILTER_EN
    check("prog_480i_2", n64_480i, 1);
`else
    check("prog_480i_2", n64_480i, 0);
`endif
    body(262); vs_edge(1'b1);
    check("prog_480i_3", n64_480i, 0);

    // Random bus traffic with irregular nDSYNC
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 7'($urandom));
    end

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/n64_vinfo_ext.md
Name: n64_vinfo_ext

Overview:
- Front-end video-info extractor on the N64 digital video bus; sits directly upstream of the deblur estimator.
- Tracks the 4-phase nDSYNC word cycle and supplies the data_cnt, vmode, n64_480i and previous-sync-word fields that the estimator consumes.
- Classifies each field as NTSC or PAL and as progressive or interlaced from sync timing alone.

Parameters:
- COLOR_W, 7, width of D_i.
- LINE_CNT_W, 10, width of the per-field line counter.
- PAL_LINE_TH, 10'd288, line count per field at or above which the field is PAL.

Ports:
- VCLK  in  1  video clock.
- nRST  in  1  reset; synchronous, active-low, sampled on VCLK.
- nDSYNC  in  1  low on the sync-word cycle.
- D_i  in  COLOR_W  N64 data bus. During a sync word: bit3 = nVSYNC, bit2 = nCLAMP, bit1 = nHSYNC, bit0 = nCSYNC.
- data_cnt  out  2  phase of the current D_i word: 0 = sync, 1 = R, 2 = G, 3 = B.
- sync_pre  out  4  last sync word seen with nDSYNC low.
- vsync_neg  out  1  one-cycle strobe: nVSYNC falling edge detected.
- vmode  out  1  0 = NTSC, 1 = PAL.
- n64_480i  out  1  1 = interlaced source.
- field_id  out  1  nHSYNC level sampled at the last vsync_neg.

Behaviour:
- All state updates on posedge VCLK. nRST low has priority over every other update.
- Reset values:
  - data_cnt = 0, sync_pre = 4'hF, vsync_neg = 0.
  - vmode = 0, n64_480i = 0, field_id = 0.
  - line_cnt = 0, frame_valid = 0.
- data_cnt:
  - nDSYNC low: data_cnt <= 1.
  - Otherwise: data_cnt <= data_cnt + 1, wrapping 3 -> 0.
  - Result: data_cnt equals the phase of the word present on D_i in the following cycle.
  - A missing nDSYNC pulse does not stall the counter; it wraps freely.
- sync_pre: updated to D_i[3:0] only on cycles with nDSYNC low. Its value before the update is the "previous" sync word used for edge detection.
- Edge detects, evaluated only on cycles with nDSYNC low:
  - vs_fall = sync_pre[3] & ~D_i[3].
  - hs_fall = sync_pre[1] & ~D_i[1].
- vsync_neg: registered vs_fall. High for exactly one VCLK, one cycle after the sync word that carries the edge.
- line_cnt (LINE_CNT_W bits):
  - Increments on hs_fall.
  - Saturates at all-ones; no wrap.
  - On vs_fall it is cleared to 0. If hs_fall occurs in the same word, the clear wins and that hs_fall is not counted.
- Field classification, on each vs_fall:
  - frame_valid = 0:
    - Set frame_valid <= 1.
    - Latch field_id <= D_i[1].
    - vmode and n64_480i are unchanged, because the first partial field after reset is discarded.
  - frame_valid = 1:
    - vmode_raw = (line_cnt >= PAL_LINE_TH).
    - i480_raw = (D_i[1] != field_id).
    - Latch field_id <= D_i[1].
    - The raw values feed the output stage defined under Optional Feature.
- A saturated line_cnt (no vsync for 2^LINE_CNT_W lines) classifies as PAL at the next vs_fall.
- Reset mid-field: all state returns to reset values and the first following field is discarded again.
- Output stability: vmode and n64_480i change only in the cycle after a vs_fall, so downstream frame-rate logic sees them stable across a whole frame.

Optional Feature:
- Macro: VINFO_FILTER_EN.
- Defined:
  - vmode and n64_480i each update only when their raw value agrees over two consecutive valid fields.
  - A one-bit pending register per output holds the previous raw value; pending registers reset to 0.
  - A single disagreeing field leaves the output unchanged.
- Undefined: vmode <= vmode_raw and n64_480i <= i480_raw directly at each valid vs_fall.

Test Plan:
- Phase counting: nDSYNC low every 4th cycle for 40 cycles -> data_cnt reads 1,2,3,0 repeating, aligned to R,G,B,sync. Drop one nDSYNC pulse -> data_cnt wraps 3 -> 0 -> 1 without stall.
- NTSC progressive: 3 fields of 262 lines, vsync falling at nHSYNC high each time -> vsync_neg pulses once per field; vmode = 0, n64_480i = 0; first field does not update the outputs.
- PAL: fields of 312 lines -> vmode = 1 after the 2nd vs_fall without the filter, after the 3rd with VINFO_FILTER_EN. Fields of 287 lines -> vmode = 0; 288 lines -> vmode = 1.
- Interlace: alternate nHSYNC level at vsync (high, low, high, ...) with 262/263 lines -> n64_480i = 1 and field_id toggles each field. Return to a constant phase -> n64_480i = 0 after 1 field (no filter) or 2 fields (filter).
- Simultaneous edges: sync word with nVSYNC and nHSYNC both falling -> line_cnt = 0 afterwards, vsync_neg = 1.
- Reset mid-field: assert nRST for 1 cycle at line 150 -> all outputs at reset values next cycle; the following vs_fall only sets frame_valid, and the outputs update on the next vs_fall.
